dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory. It shares the memory's address/data/write-enable port between the CPU datapath (requester 0) and a host/loader port (requester 1) through a req/gnt handshake with round-robin fairness. It also registers each accepted transaction into one access stage and returns registered read data with a valid pulse. It sits between the two requesters and the memory, replacing the direct address-mux-to-memory connection.

## Interface
- ADDR_W, 8, address width of the data memory
- DATA_W, 8, data width of the data memory
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset
- req0, req1  input  1 each  access request from requester 0 (CPU) and requester 1 (host)
- we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN
- addr0, addr1  input  ADDR_W each  access address
- wdata0, wdata1  input  DATA_W each  write data
- lock1  input  1  requester 1 atomic-sequence hold (see Configuration)
- gnt0, gnt1  output  1 each  combinational grant; transaction accepted at the rising edge where reqN && gntN
- rdata0, rdata1  output  DATA_W each  registered read data
- rvalid0, rvalid1  output  1 each  one-cycle pulse: rdataN holds the result of a read accepted from requester N
- mem_addr  output  ADDR_W  memory address
- mem_din  output  DATA_W  memory write data
- mem_we  output  1  memory write enable; memory writes on the rising clk edge
- mem_dout  input  DATA_W  memory combinational read data

## Operation
- Arbitration: combinational from req0, req1, the pointer `last`, and the lock state. At most one of gnt0/gnt1 is high. gntN is never high without reqN.
- Round-robin: only one requesting -> it wins. Both requesting -> the requester != `last` wins. At each accept, `last` <= winner.
- Accept edge: the access stage latches {valid=1, owner, we, addr, wdata}. With no accept, valid <= 0. The stage never stalls, so one accept per cycle is possible.
- Access cycle: while valid=1, mem_addr/mem_din = latched addr/wdata and mem_we = valid && we. While valid=0, mem_we=0 and mem_addr/mem_din = 0.
- Read completion: at the edge ending an access cycle with valid && !we, rdata[owner] <= mem_dout and rvalid[owner] <= 1. Otherwise rvalid <= 0. rdataN holds its value until the next read for N.
- Writes produce no rvalid.
- Lock FSM, states OPEN and LOCKED:
  - OPEN -> LOCKED on an accept from requester 1 with lock1=1.
  - In LOCKED: gnt0=0 and gnt1=req1.
  - LOCKED -> OPEN on an accept from requester 1 with lock1=0, or in any cycle with req1=0 && lock1=0.
- Requester obligations: hold reqN, weN, addrN, wdataN stable until the accept edge. A requester that deasserts reqN before gntN abandons the request with no side effect.

## Timing
- Reset (async assert, sync release) sets: valid=0, mem_we=0, mem_addr=0, mem_din=0, rvalid0/1=0, rdata0/1=0, `last`=1 (requester 0 wins the first tie), lock state OPEN. gnt follows req combinationally once reset is released; gnt0/1=0 while rst_n=0.
- Reset asserted during an access cycle: mem_we drops immediately and the in-flight write is lost; no rvalid for an in-flight read.
- Write latency: the accept edge is E0; the memory write happens at E1.
- Read latency: accept at E0, memory read during cycle E0-E1, rvalidN high during cycle E1-E2.
- Back-to-back: accepts at consecutive edges give consecutive access cycles and consecutive rvalid pulses. Read-after-write to the same address in the next cycle returns the new data.
- Simultaneous requests: both requesters get alternating grants, one accept per cycle.

## Configuration
- DMEM_ARB_LOCK_EN defined: lock1 and the LOCKED state behave as in Operation.
- DMEM_ARB_LOCK_EN undefined: lock1 is ignored (port kept), the FSM is permanently OPEN, and arbitration is pure round-robin.

## Test plan
- Reset defaults: hold rst_n=0 with req0=req1=1 -> gnt0=gnt1=0, mem_we=0, rvalid=0. Release -> first grant goes to requester 0.
- Single read: preload addr 0x10=0x5A; req0 read addr 0x10 -> gnt0 at once; mem_addr=0x10 next cycle; rvalid0=1 with rdata0=0x5A two cycles after accept; rvalid1 stays 0.
- Contention: req0 and req1 held high for 4 accepts -> grants alternate 0,1,0,1; no cycle has both gnt high.
- Write then read: req1 writes 0xC3 to 0x20, then immediately reads 0x20 -> mem_we=1 for exactly one cycle, then rdata1=0xC3 with rvalid1.
- Lock (macro on): req1 with lock1=1 for three accepts while req0=1 -> gnt0=0 throughout. The fourth req1 accept with lock1=0 -> next grant goes to req0. Same stimulus with the macro off -> alternating grants.
- Reset mid-write: drop rst_n during an access cycle of a write of 0xFF to 0x30 -> mem_we falls immediately; addr 0x30 is unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and single-stage access sequencer for the shared data memory port.
// Optional requester-1 atomic lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [0:0] {StOpen, StLocked} lock_e;

  lock_e             lock_q;
  logic              last_q;
  logic              valid_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic acc0, acc1, accept, rd_done;

`ifndef DMEM_ARB_LOCK_EN
  logic unused_lock1;
  assign unused_lock1 = lock1;
`endif

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (lock_q == StLocked) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign acc0    = req0 & gnt0;
  assign acc1    = req1 & gnt1;
  assign accept  = acc0 | acc1;
  assign rd_done = valid_q & ~we_q;

  // The stage registers are zeroed when idle so the memory port is quiet.
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign mem_we   = we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= StOpen;
      last_q  <= 1'b1;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      valid_q <= accept;
      owner_q <= acc1;
      if (accept) begin
        last_q <= acc1;
      end
      we_q    <= acc1 ? we1    : (acc0 & we0);
      addr_q  <= acc1 ? addr1  : (acc0 ? addr0  : '0);
      wdata_q <= acc1 ? wdata1 : (acc0 ? wdata0 : '0);

      rvalid0 <= rd_done & ~owner_q;
      rvalid1 <= rd_done & owner_q;
      if (rd_done && !owner_q) begin
        rdata0 <= mem_dout;
      end
      if (rd_done && owner_q) begin
        rdata1 <= mem_dout;
      end

`ifdef DMEM_ARB_LOCK_EN
      unique case (lock_q)
        StOpen: begin
          if (acc1 && lock1) begin
            lock_q <= StLocked;
          end
        end
        StLocked: begin
          if ((acc1 || !req1) && !lock1) begin
            lock_q <= StOpen;
          end
        end
        default: lock_q <= StOpen;
      endcase
`else
      lock_q <= StOpen;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a transaction-level reference model
// and a behavioural memory; follows DMEM_ARB_LOCK_EN the same way as the design.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];

  typedef struct {
    logic       owner;
    logic [7:0] data;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  // Reference state: arbitration pointer, lock, pending write, expected memory port.
  logic       m_last, m_locked;
  logic       pend_w;
  logic [7:0] pend_a, pend_d;
  logic       e_valid, e_we;
  logic [7:0] e_addr, e_din;
  logic       mg0, mg1, ma0, ma1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void predict(output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (m_locked) g1 = req1;
    else if (req0 && req1) begin
      g0 = m_last;
      g1 = !m_last;
    end else begin
      g0 = req0;
      g1 = req1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = 1'b1; m_locked = 1'b0; pend_w = 1'b0;
      e_valid = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
      sb.delete();
    end else begin
      cyc++;
      if (pend_w) shadow[pend_a] = pend_d;
      pend_w = 1'b0;
      predict(mg0, mg1);
      ma0 = req0 && mg0;
      ma1 = req1 && mg1;
`ifdef DMEM_ARB_LOCK_EN
      if (!m_locked && ma1 && lock1) m_locked = 1'b1;
      else if (m_locked && (ma1 || !req1) && !lock1) m_locked = 1'b0;
`endif
      e_valid = ma0 || ma1;
      e_we    = ma1 ? we1 : (ma0 && we0);
      e_addr  = ma1 ? addr1 : addr0;
      e_din   = ma1 ? wdata1 : wdata0;
      if (e_valid) begin
        m_last = ma1;
        if (e_we) begin
          pend_w = 1'b1; pend_a = e_addr; pend_d = e_din;
        end else begin
          sb.push_back('{owner: ma1, data: shadow[e_addr], due: cyc + 1});
        end
      end
    end
  end

  // Monitor: compares the port, grants and read returns every cycle away from the edge.
  always @(negedge clk) begin
    logic cg0, cg1;
    exp_t e;
    if (rst_n) begin
      predict(cg0, cg1);
      chk("gnt0", gnt0, cg0);
      chk("gnt1", gnt1, cg1);
      chk("mem_we", mem_we, e_valid && e_we);
      chk("mem_addr", mem_addr, e_valid ? e_addr : 8'h00);
      chk("mem_din", mem_din, e_valid ? e_din : 8'h00);
      if (rvalid0 || rvalid1) begin
        chk("rvalid_onehot", rvalid0 && rvalid1, 0);
        chk("rvalid_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rvalid_owner", rvalid1, e.owner);
          chk("rvalid_cycle", cyc, e.due);
          chk("rdata", e.owner ? rdata1 : rdata0, e.data);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("rvalid_missing", rvalid0 || rvalid1, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic access(input bit r, input bit we, input logic [7:0] a, input logic [7:0] d,
                        input bit lk);
    int n;
    logic g;
    if (r) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; lock1 = lk;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    n = 0;
    do begin
      @(negedge clk);
      g = r ? gnt1 : gnt0;
      @(posedge clk);
      #2;
      n++;
    end while (!g && n < 200);
    chk("grant_timeout", g, 1);
  endtask

  task automatic idle(input bit r);
    if (r) begin
      req1 = 1'b0; lock1 = 1'b0;
    end else begin
      req0 = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      shadow[i] = v;
    end
    mem[8'h10] = 8'h5A; shadow[8'h10] = 8'h5A;
    mem[8'h30] = 8'h11; shadow[8'h30] = 8'h11;

    // Reset with both requesters asking.
    req0 = 1'b1; addr0 = 8'h10; req1 = 1'b1; addr1 = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    rst_n = 1'b1;

    // First tie after reset goes to requester 0; it reads the preloaded 0x5A.
    fork
      begin access(0, 0, 8'h10, 8'h00, 0); idle(0); end
      begin access(1, 0, 8'h00, 8'h00, 0); idle(1); end
    join
    repeat (3) begin @(posedge clk); #2; end

    // Write then immediate read-back from requester 1.
    access(1, 1, 8'h20, 8'hC3, 0);
    access(1, 0, 8'h20, 8'h00, 0);
    idle(1);
    repeat (3) begin @(posedge clk); #2; end

    // Sustained contention.
    fork
      begin
        repeat (4) access(0, 0, 8'($urandom_range(0, 15)), 8'($urandom), 0);
        idle(0);
      end
      begin
        repeat (4) access(1, 0, 8'($urandom_range(0, 15)), 8'($urandom), 0);
        idle(1);
      end
    join

    // Locked sequence from requester 1 while requester 0 waits.
    fork
      begin access(0, 0, 8'h03, 8'h00, 0); idle(0); end
      begin
        repeat (3) access(1, 1, 8'($urandom_range(0, 15)), 8'($urandom), 1);
        access(1, 0, 8'h05, 8'h00, 0);
        idle(1);
      end
    join
    repeat (3) begin @(posedge clk); #2; end

    // Random traffic on both ports.
    fork
      for (int i = 0; i < 80; i++) begin
        access(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 0);
        if ($urandom_range(0, 2) == 0) begin
          idle(0);
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #2; end
        end
      end
      for (int j = 0; j < 80; j++) begin
        access(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
               $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 2) == 0) begin
          idle(1);
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #2; end
        end
      end
    join
    idle(0);
    idle(1);
    repeat (4) begin @(posedge clk); #2; end

    // Reset lands in the access cycle of a write: the write must be lost.
    access(1, 1, 8'h30, 8'hFF, 0);
    idle(1);
    chk("mid_write_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_we", mem_we, 0);
    repeat (2) begin @(posedge clk); #2; end
    chk("mem30_kept", mem[8'h30], 8'h11);
    rst_n = 1'b1;
    access(0, 0, 8'h30, 8'h00, 0);
    idle(0);

    repeat (5) begin @(posedge clk); #2; end
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
